// File: rtl/adpcm_pkg.sv
// adpcm_pkg: shared widths and state type for the ADPCM block controller
package adpcm_pkg;
  localparam int SAMPLE_W = 16;
  localparam int CODE_W = 4;
  localparam int NIBBLES_PER_WORD = 4;
  localparam int WORD_W = CODE_W * NIBBLES_PER_WORD;
  typedef enum logic [1:0] {RST, RUN, FLUSH} blk_state_t;
endpackage

// File: rtl/adpcm_nibble_packer.sv
// adpcm_nibble_packer: shifts encoder codes into words and holds the output register
module adpcm_nibble_packer
  import adpcm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              word_end,
  input  logic              blk_end,
  input  logic [CODE_W-1:0] enc_code,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);
  logic cap, cap_word, cap_last, load;
  logic [WORD_W-CODE_W-1:0] acc;
  assign load = cap && cap_word;
  // enc_code is valid one edge after the strobe, so the accept context is delayed to match
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cap <= 1'b0;
      cap_word <= 1'b0;
      cap_last <= 1'b0;
      acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      cap <= shift_en;
      cap_word <= word_end;
      cap_last <= blk_end;
      if (cap) acc <= {enc_code, acc[WORD_W-CODE_W-1:CODE_W]};
      if (load) begin
        out_data <= {enc_code, acc};
        out_last <= cap_last;
      end
      out_valid <= load || (out_valid && !out_ready);
    end
endmodule

// File: rtl/adpcm_block_ctrl.sv
// adpcm_block_ctrl: per-block sequencer feeding the ADPCM encoder and packing its codes
module adpcm_block_ctrl
  import adpcm_pkg::*;
#(
  parameter int BLOCK_LEN = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic                enc_en,
  output logic                enc_reset,
  output logic [SAMPLE_W-1:0] enc_sample,
  input  logic [CODE_W-1:0]   enc_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_last,
  output logic                blk_done
);
  localparam int CW = $clog2(BLOCK_LEN);
  localparam int NW = $clog2(NIBBLES_PER_WORD);
  localparam logic [CW-1:0] LAST_SMP = CW'(BLOCK_LEN - 1);
  localparam logic [NW-1:0] LAST_NIB = NW'(NIBBLES_PER_WORD - 1);
  blk_state_t state, state_nx;
  logic [NW-1:0] nib_cnt;
  logic [CW-1:0] smp_cnt;
  logic accept, blk_end;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= RST;
      nib_cnt <= '0;
      smp_cnt <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        nib_cnt <= nib_cnt + NW'(1);
        smp_cnt <= blk_end ? '0 : smp_cnt + CW'(1);
      end
    end
  // the last nibble of a word is held off until the output register is free
  always_comb begin
    in_ready = (state == RUN) && (nib_cnt != LAST_NIB || !out_valid || out_ready);
    accept = in_valid && in_ready;
    blk_end = smp_cnt == LAST_SMP;
    enc_en = accept;
    enc_reset = state != RUN;
    state_nx = (state == RUN && !(accept && blk_end)) || state != RUN ? RUN : FLUSH;
  end
  assign enc_sample = in_sample;
  assign blk_done = out_valid && out_ready && out_last;
  adpcm_nibble_packer u_packer (
    .clk(clk),
    .reset(reset),
    .shift_en(accept),
    .word_end(nib_cnt == LAST_NIB),
    .blk_end(blk_end),
    .enc_code(enc_code),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last)
  );
endmodule
